bp_cfg_loader: RTL
==================

Name: bp_cfg_loader

Overview:
- Boot-time configuration sequencer. Sits between the processor parameter set (core count, CCE microcode depth, NoC credits) and the per-tile configuration bus.
- After start, it freezes each core, programs the core ID, CCE microcode and CCE mode, then unfreezes the core.
- Writes are issued as valid/ready commands. Outstanding writes are bounded by a credit counter, and the block reports done once every write has been acknowledged.

Parameters:
- num_core_p, 1, number of cores to configure (cc_x_dim*cc_y_dim); range 1..64
- cfg_addr_width_p, 20, config register address width
- cfg_data_width_p, 64, config write data width
- ucode_els_p, 256, CCE microcode entries (2^cce_pc_width); power of two, >=2
- max_credits_p, 8, maximum outstanding writes (coh_noc_max_credits)
- cce_mode_p, 1, value written to the CCE mode register (0 uncached, 1 normal)

Ports:
- clk_i  in  1  clock
- reset_n_i  in  1  asynchronous active-low reset
- start_i  in  1  one-cycle pulse that begins the sequence; ignored unless idle
- ucode_addr_o  out  clog2(ucode_els_p)  microcode ROM read address
- ucode_v_o  out  1  microcode ROM read enable
- ucode_data_i  in  cfg_data_width_p  ROM data, valid 1 cycle after ucode_v_o
- cmd_v_o  out  1  config write valid
- cmd_ready_i  in  1  config write ready; handshake = cmd_v_o & cmd_ready_i
- cmd_core_o  out  clog2(num_core_p) (min 1)  target core index
- cmd_addr_o  out  cfg_addr_width_p  register address
- cmd_data_o  out  cfg_data_width_p  write data
- resp_v_i  in  1  write acknowledge
- resp_yumi_o  out  1  ack consume; equals resp_v_i
- busy_o  out  1  sequence in progress
- done_o  out  1  sticky; sequence complete and all acks received

Behaviour:
- Reset (async assert, sync deassert assumed upstream):
  - state=IDLE; core/ucode counters=0; credits=0.
  - All outputs 0.
- Register map (package constants):
  - FREEZE=0x00002, CORE_ID=0x00004, CCE_MODE=0x00008.
  - UCODE_BASE=0x08000; entry i written at UCODE_BASE+i.
- FSM:
  - IDLE: start_i -> FREEZE; clear done_o.
  - FREEZE: write data=1 -> CORE_ID.
  - CORE_ID: write data=core index, zero-extended -> UC_RD.
  - UC_RD: ucode_v_o=1, ucode_addr_o=idx; one cycle -> UC_WR.
  - UC_WR: the first cycle captures ucode_data_i into a holding register. Write that register to UCODE_BASE+idx. On handshake: if idx==ucode_els_p-1, clear idx -> MODE; else idx++ -> UC_RD.
  - MODE: write data=cce_mode_p -> UNFREEZE.
  - UNFREEZE: write data=0. If core==num_core_p-1 -> DRAIN; else core++ -> FREEZE.
  - DRAIN: wait until credits==0 -> DONE.
  - DONE: done_o=1, busy_o=0; start_i -> FREEZE (restart allowed).
- Write states advance only on handshake. cmd_v_o is held, with addr/data/core stable, until ready.
- cmd_v_o is asserted in write states only when credits<max_credits_p.
- Credit counter, width clog2(max_credits_p+1):
  - +1 on command handshake.
  - -1 on resp_v_i.
  - Unchanged when both occur in the same cycle.
- resp_v_i with credits==0 is an error: assertion fires; counter saturates at 0.
- busy_o=1 in every state except IDLE and DONE.
- Total writes = num_core_p*(ucode_els_p+4).
- cmd_ready_i is ignored when cmd_v_o=0.
- reset_n_i low mid-sequence returns to IDLE immediately; outstanding acks after reset are dropped (counter held 0, no assertion during first reset-release cycle only).

Decomposition:
- bp_cfg_pkg holds:
  - the register address constants;
  - the state enum bp_cfg_loader_state_e;
  - the struct bp_cfg_cmd_s {core, addr, data}.
- One sub-module, bp_cfg_credit_counter: up/down saturating counter with full/empty flags, parameterised by max_credits_p.

Test Plan:
- num_core_p=1, ucode_els_p=4, ready=1, ack 1 cycle after each write -> 8 writes in order:
  - FREEZE=1, CORE_ID=0;
  - UCODE 0x08000..0x08003 carrying ROM data;
  - CCE_MODE=1, FREEZE=0.
  - done_o rises after the 8th ack.
- num_core_p=2, ucode_els_p=4 -> 16 writes; core 0's sequence completes before any core 1 write; core 1's CORE_ID data=1.
- max_credits_p=2, acks withheld -> exactly 2 handshakes then cmd_v_o=0; one ack releases exactly one more write.
- cmd_ready_i toggled randomly 50% -> no write lost or duplicated; addr/data stable while cmd_v_o=1 & !cmd_ready_i.
- Simultaneous handshake and resp_v_i at credits=1 -> credits stays 1.
- reset_n_i pulled low during UC_WR of entry 2 -> outputs 0 asynchronously, state IDLE, done_o=0. A new start_i replays the full sequence from FREEZE of core 0.

Source files
------------

// File: rtl/bp_cfg_pkg.sv
// Shared definitions for the boot-time configuration loader: register map,
// sequencer states and the configuration write command layout.
package bp_cfg_pkg;

    // Widest fields any instance may use; the loader slices down to its parameters
    localparam int unsigned CFG_CORE_MAX_W = 6;
    localparam int unsigned CFG_ADDR_MAX_W = 32;
    localparam int unsigned CFG_DATA_MAX_W = 64;

    // Per-tile configuration register map
    localparam logic [CFG_ADDR_MAX_W-1:0] CFG_ADDR_FREEZE     = 32'h0000_0002;
    localparam logic [CFG_ADDR_MAX_W-1:0] CFG_ADDR_CORE_ID    = 32'h0000_0004;
    localparam logic [CFG_ADDR_MAX_W-1:0] CFG_ADDR_CCE_MODE   = 32'h0000_0008;
    localparam logic [CFG_ADDR_MAX_W-1:0] CFG_ADDR_UCODE_BASE = 32'h0000_8000;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FREEZE,
        S_CORE_ID,
        S_UC_RD,
        S_UC_WR,
        S_MODE,
        S_UNFREEZE,
        S_DRAIN,
        S_DONE
    } bp_cfg_loader_state_e;

    typedef struct packed {
        logic [CFG_CORE_MAX_W-1:0] core;
        logic [CFG_ADDR_MAX_W-1:0] addr;
        logic [CFG_DATA_MAX_W-1:0] data;
    } bp_cfg_cmd_s;

endpackage

// File: rtl/bp_cfg_credit_counter.sv
// Up/down credit counter tracking outstanding configuration writes.
// Saturates at both ends; simultaneous increment and decrement cancel.
module bp_cfg_credit_counter #(
    parameter  int unsigned max_credits_p = 8,
    localparam int unsigned CredW         = $clog2(max_credits_p + 1)
) (
    input  logic             clk_i,
    input  logic             reset_n_i,
    input  logic             i_inc,
    input  logic             i_dec,
    output logic [CredW-1:0] o_count,
    output logic             o_full,
    output logic             o_empty
);

    logic [CredW-1:0] r_count;

    // Count handshakes up and acknowledges down, clamped to [0, max_credits_p]
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_count <= '0;
        end else if (i_inc && !i_dec) begin
            if (r_count != CredW'(max_credits_p)) begin
                r_count <= r_count + CredW'(1);
            end
        end else if (!i_inc && i_dec) begin
            if (r_count != '0) begin
                r_count <= r_count - CredW'(1);
            end
        end
    end

    assign o_count = r_count;
    assign o_full  = (r_count == CredW'(max_credits_p));
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/bp_cfg_loader.sv
// Boot-time configuration sequencer: for every core it freezes the core,
// programs its ID, CCE microcode and CCE mode, then unfreezes it. Writes
// are credit limited and done_o waits for every acknowledge.
// Address and data widths are limited to 32 and 64 bits respectively.
module bp_cfg_loader
    import bp_cfg_pkg::*;
#(
    parameter  int unsigned num_core_p       = 1,
    parameter  int unsigned cfg_addr_width_p = 20,
    parameter  int unsigned cfg_data_width_p = 64,
    parameter  int unsigned ucode_els_p      = 256,
    parameter  int unsigned max_credits_p    = 8,
    parameter  int unsigned cce_mode_p       = 1,
    localparam int unsigned UcAddrW          = $clog2(ucode_els_p),
    localparam int unsigned CoreW            = (num_core_p > 1) ? $clog2(num_core_p) : 1
) (
    input  logic                        clk_i,
    input  logic                        reset_n_i,
    input  logic                        start_i,
    output logic [UcAddrW-1:0]          ucode_addr_o,
    output logic                        ucode_v_o,
    input  logic [cfg_data_width_p-1:0] ucode_data_i,
    output logic                        cmd_v_o,
    input  logic                        cmd_ready_i,
    output logic [CoreW-1:0]            cmd_core_o,
    output logic [cfg_addr_width_p-1:0] cmd_addr_o,
    output logic [cfg_data_width_p-1:0] cmd_data_o,
    input  logic                        resp_v_i,
    output logic                        resp_yumi_o,
    output logic                        busy_o,
    output logic                        done_o
);

    localparam int unsigned CredW = $clog2(max_credits_p + 1);

    bp_cfg_loader_state_e        r_state;
    logic [CoreW-1:0]            r_core;
    logic [UcAddrW-1:0]          r_idx;
    logic [cfg_data_width_p-1:0] r_hold;
    logic                        r_uc_first;
    logic                        r_done;
    logic                        r_rel_first;

    bp_cfg_cmd_s      w_cmd;
    logic             w_wr_state;
    logic             w_hs;
    logic [CredW-1:0] w_credits;
    logic             w_full;
    logic             w_empty;
    logic             w_unused_cmd;

    bp_cfg_credit_counter #(
        .max_credits_p(max_credits_p)
    ) u_credits (
        .clk_i    (clk_i),
        .reset_n_i(reset_n_i),
        .i_inc    (w_hs),
        .i_dec    (resp_v_i),
        .o_count  (w_credits),
        .o_full   (w_full),
        .o_empty  (w_empty)
    );

    // Decode the pending write from the registered state; nothing here
    // depends on cmd_ready_i, so fields stay put while a write is stalled
    always_comb begin
        w_cmd      = '0;
        w_wr_state = 1'b0;
        w_cmd.core = CFG_CORE_MAX_W'(r_core);
        case (r_state)
            S_FREEZE: begin
                w_wr_state = 1'b1;
                w_cmd.addr = CFG_ADDR_FREEZE;
                w_cmd.data = 64'd1;
            end
            S_CORE_ID: begin
                w_wr_state = 1'b1;
                w_cmd.addr = CFG_ADDR_CORE_ID;
                w_cmd.data = 64'(r_core);
            end
            S_UC_WR: begin
                // First cycle is spent latching ROM data into r_hold
                w_wr_state = !r_uc_first;
                w_cmd.addr = CFG_ADDR_UCODE_BASE + 32'(r_idx);
                w_cmd.data = 64'(r_hold);
            end
            S_MODE: begin
                w_wr_state = 1'b1;
                w_cmd.addr = CFG_ADDR_CCE_MODE;
                w_cmd.data = 64'(cce_mode_p);
            end
            S_UNFREEZE: begin
                w_wr_state = 1'b1;
                w_cmd.addr = CFG_ADDR_FREEZE;
                w_cmd.data = '0;
            end
            default: begin
                w_wr_state = 1'b0;
            end
        endcase
    end

    assign cmd_v_o      = w_wr_state & ~w_full;
    assign w_hs         = cmd_v_o & cmd_ready_i;
    assign cmd_core_o   = w_cmd.core[CoreW-1:0];
    assign cmd_addr_o   = w_cmd.addr[cfg_addr_width_p-1:0];
    assign cmd_data_o   = w_cmd.data[cfg_data_width_p-1:0];
    assign w_unused_cmd = ^w_cmd;
    assign ucode_v_o    = (r_state == S_UC_RD);
    assign ucode_addr_o = r_idx;
    assign resp_yumi_o  = resp_v_i;
    assign busy_o       = (r_state != S_IDLE) && (r_state != S_DONE);
    assign done_o       = r_done;

    // Sequencer: per core FREEZE, CORE_ID, (UC_RD, UC_WR) per entry, MODE, UNFREEZE
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state    <= S_IDLE;
            r_core     <= '0;
            r_idx      <= '0;
            r_hold     <= '0;
            r_uc_first <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start_i) begin
                        r_state <= S_FREEZE;
                        r_core  <= '0;
                        r_idx   <= '0;
                        r_done  <= 1'b0;
                    end
                end
                S_FREEZE: begin
                    if (w_hs) r_state <= S_CORE_ID;
                end
                S_CORE_ID: begin
                    if (w_hs) r_state <= S_UC_RD;
                end
                S_UC_RD: begin
                    r_state    <= S_UC_WR;
                    r_uc_first <= 1'b1;
                end
                S_UC_WR: begin
                    if (r_uc_first) begin
                        r_hold     <= ucode_data_i;
                        r_uc_first <= 1'b0;
                    end else if (w_hs) begin
                        if (r_idx == UcAddrW'(ucode_els_p - 1)) begin
                            r_idx   <= '0;
                            r_state <= S_MODE;
                        end else begin
                            r_idx   <= r_idx + UcAddrW'(1);
                            r_state <= S_UC_RD;
                        end
                    end
                end
                S_MODE: begin
                    if (w_hs) r_state <= S_UNFREEZE;
                end
                S_UNFREEZE: begin
                    if (w_hs) begin
                        if (r_core == CoreW'(num_core_p - 1)) begin
                            r_state <= S_DRAIN;
                        end else begin
                            r_core  <= r_core + CoreW'(1);
                            r_state <= S_FREEZE;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_empty) begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Marks the first cycle after reset release, when stale acks are tolerated
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_rel_first <= 1'b1;
        end else begin
            r_rel_first <= 1'b0;
        end
    end

    a_no_ack_underflow: assert property (
        @(posedge clk_i) disable iff (!reset_n_i)
        !(resp_v_i && (w_credits == '0) && !r_rel_first)
    );

endmodule
